// File: rtl/ext_mem_model.sv
// Block-RAM-backed SysAD-style responder: line and single-doubleword reads and writes, wrapped critical-word-first bursts, and out-of-range or bad-size errors.
// Latency: the first read beat follows LAT idle qualified cycles after accept; an error beat comes the cycle after accept; write beats are taken one per qualified cycle.
// Backpressure: extrdy is low in WAIT/RD/ERR, and requests seen then are dropped; in WR, extreq=0 stalls the burst without advancing it.
module ext_mem_model #(
    parameter int    AW       = 12,
    parameter int    LAT      = 0,
    parameter int    IBEATS   = 4,
    parameter int    DBEATS   = 2,
    parameter string INITFILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        phi2,
    input  logic        extreq,
    input  logic        extwr,
    input  logic [4:0]  extsz,
    input  logic [31:0] extaddr,
    input  logic        extsrc,
    input  logic [63:0] extwdata,
    output logic        extrdy,
    output logic        extreply,
    output logic        extreplyto,
    output logic [63:0] extrdata,
    output logic        exterror
);
    localparam int DEPTH = 1 << AW;
    localparam int BW    = 8;

    typedef enum logic [2:0] {IDLE, WAIT, RD, WR, ERR} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [BW-1:0] n_q, n_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          src_q, src_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;

    logic          we;
    logic [AW-1:0] widx;
    logic [7:0]    wbe;

    logic [63:0]   mem [DEPTH];

    logic [AW-1:0] req_base;
    logic [2:0]    req_off;
    logic [BW-1:0] req_n;
    logic          req_line;
    logic          req_bad;
    logic [5:0]    span_end;
    logic [7:0]    single_be;

    // Index of beat i inside the naturally aligned n-doubleword line holding b.
    function automatic logic [AW-1:0] wrap_idx(input logic [AW-1:0] b,
                                               input logic [BW-1:0] n,
                                               input logic [BW-1:0] i);
        logic [AW-1:0] m;
        m = AW'(n - 8'd1);
        return (b & ~m) | ((b + AW'(i)) & m);
    endfunction

    assign req_base = extaddr[AW+2:3];
    assign req_off  = extaddr[2:0];
    assign req_line = (extsz == 5'd31) || (extsz == 5'd15);
    assign req_n    = (extsz == 5'd31) ? BW'(IBEATS) :
                      (extsz == 5'd15) ? BW'(DBEATS) : BW'(1);
    assign span_end = {3'b000, req_off} + {1'b0, extsz};
    assign req_bad  = ((extaddr >> (AW + 3)) != 32'd0)
                   || (!req_line && (extsz > 5'd7))
                   || (!req_line && (span_end > 6'd7))
                   || (req_line && (req_off != 3'd0));

    always_comb begin
        single_be = 8'h00;
        for (int k = 0; k < 8; k++) begin
            single_be[k] = (3'(k) >= req_off) && ({3'b000, 3'(k)} <= span_end);
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        n_d      = n_q;
        beat_d   = beat_q;
        cnt_d    = cnt_q;
        src_d    = src_q;
        rd_idx_d = rd_idx_q;
        we       = 1'b0;
        widx     = base_q;
        wbe      = 8'h00;
        extrdy   = 1'b0;
        extreply = 1'b0;
        exterror = 1'b0;
        case (state_q)
            IDLE: begin
                extrdy = 1'b1;
                if (extreq) begin
                    base_d   = req_base;
                    n_d      = req_n;
                    src_d    = extsrc;
                    cnt_d    = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
                    rd_idx_d = req_base;
                    if (req_bad) begin
                        state_d = ERR;
                    end else if (extwr) begin
                        // Beat 0 of a write rides on the request itself.
                        we      = 1'b1;
                        widx    = req_base;
                        wbe     = req_line ? 8'hFF : single_be;
                        beat_d  = BW'(1);
                        state_d = (req_n > BW'(1)) ? WR : IDLE;
                    end else begin
                        beat_d  = '0;
                        state_d = (LAT > 0) ? WAIT : RD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD: begin
                extreply = 1'b1;
                if (beat_q == n_q - BW'(1)) begin
                    state_d = IDLE;
                end else begin
                    beat_d   = beat_q + BW'(1);
                    rd_idx_d = wrap_idx(base_q, n_q, beat_q + BW'(1));
                end
            end
            WR: begin
                extrdy = 1'b1;
                if (extreq) begin
                    we   = 1'b1;
                    widx = wrap_idx(base_q, n_q, beat_q);
                    wbe  = 8'hFF;
                    if (beat_q == n_q - BW'(1)) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            ERR: begin
                extreply = 1'b1;
                exterror = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            n_q      <= BW'(1);
            beat_q   <= '0;
            cnt_q    <= '0;
            src_q    <= 1'b0;
            rd_idx_q <= '0;
        end else if (phi2) begin
            state_q  <= state_d;
            base_q   <= base_d;
            n_q      <= n_d;
            beat_q   <= beat_d;
            cnt_q    <= cnt_d;
            src_q    <= src_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    // Contents survive reset, so the array has no reset term.
    always @(posedge clk) begin
        if (phi2 && we && reset) begin
            for (int k = 0; k < 8; k++) begin
                if (wbe[k]) begin
                    mem[widx][63-8*k -: 8] <= extwdata[63-8*k -: 8];
                end
            end
        end
    end

    assign extreplyto = src_q;
    assign extrdata   = (state_q == RD) ? mem[rd_idx_q] : 64'd0;

endmodule
